// File: rtl/dmem_port_arbiter.sv
// Two-lane data-memory port arbiter: lane A (older) and lane B (younger) share one
// single-cycle memory port; a same-cycle conflict defers B by one cycle.
module dmem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                flush_i,
    input  logic                a_req_i,
    input  logic                b_req_i,
    input  logic [3:0]          a_we_i,
    input  logic [3:0]          b_we_i,
    input  logic [XLEN-1:0]     a_addr_i,
    input  logic [XLEN-1:0]     b_addr_i,
    input  logic [XLEN-1:0]     a_wdata_i,
    input  logic [XLEN-1:0]     b_wdata_i,
    output logic                a_gnt_o,
    output logic                b_gnt_o,
    output logic                a_rvalid_o,
    output logic                b_rvalid_o,
    output logic [XLEN-1:0]     a_rdata_o,
    output logic [XLEN-1:0]     b_rdata_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [3:0]          mem_we_o,
    output logic                mem_re_o,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                stall_o,
    output logic [CntWidth-1:0] conflict_cnt_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        B_PEND = 1'b1
    } state_t;

    localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  a_gnt_s;
    logic                  b_gnt_s;
    logic                  stall_s;
    logic                  conflict_s;
    logic                  own_a_r;
    logic                  own_b_r;
    logic [CntWidth-1:0]   cnt_r;

    // Grant decision; reset and flush both force every grant low.
    always_comb begin
        a_gnt_s     = 1'b0;
        b_gnt_s     = 1'b0;
        stall_s     = 1'b0;
        conflict_s  = 1'b0;
        state_nxt_s = state_r;
        if (!rstn_i || flush_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (a_req_i) begin
                        a_gnt_s = 1'b1;
                        if (b_req_i) begin
                            stall_s     = 1'b1;
                            conflict_s  = 1'b1;
                            state_nxt_s = B_PEND;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else if (b_req_i) begin
                        b_gnt_s     = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                B_PEND: begin
                    // The pending B is older in program order than any new A.
                    b_gnt_s     = b_req_i;
                    stall_s     = a_req_i;
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Memory port mux driven by whichever lane holds the grant.
    always_comb begin
        mem_addr_o  = {XLEN{1'b0}};
        mem_wdata_o = {XLEN{1'b0}};
        mem_we_o    = 4'b0000;
        mem_re_o    = 1'b0;
        if (a_gnt_s) begin
            mem_addr_o  = a_addr_i;
            mem_wdata_o = a_wdata_i;
            mem_we_o    = a_we_i;
            mem_re_o    = (a_we_i == 4'b0000);
        end else if (b_gnt_s) begin
            mem_addr_o  = b_addr_i;
            mem_wdata_o = b_wdata_i;
            mem_we_o    = b_we_i;
            mem_re_o    = (b_we_i == 4'b0000);
        end else begin
            mem_addr_o  = {XLEN{1'b0}};
        end
    end

    // Load-return steering; a flush cancels the response of last cycle's load.
    always_comb begin
        a_rvalid_o = own_a_r && !flush_i;
        b_rvalid_o = own_b_r && !flush_i;
        if (a_rvalid_o) begin
            a_rdata_o = mem_rdata_i;
        end else begin
            a_rdata_o = {XLEN{1'b0}};
        end
        if (b_rvalid_o) begin
            b_rdata_o = mem_rdata_i;
        end else begin
            b_rdata_o = {XLEN{1'b0}};
        end
    end

    assign a_gnt_o        = a_gnt_s;
    assign b_gnt_o        = b_gnt_s;
    assign stall_o        = stall_s;
    assign conflict_cnt_o = cnt_r;

    // FSM state, load owner tags and saturating conflict counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            own_a_r <= 1'b0;
            own_b_r <= 1'b0;
            cnt_r   <= {CntWidth{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            own_a_r <= a_gnt_s && (a_we_i == 4'b0000);
            own_b_r <= b_gnt_s && (b_we_i == 4'b0000);
            if (conflict_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32 (riscv_pkg XLEN), meaning address/data width.
REQ-002 SHALL have parameter CntWidth, default 16, meaning conflict counter width.
REQ-003 SHALL have port clk_i  input  1  system clock; sole clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  pipeline flush; squashes pending/in-flight lane traffic.
REQ-006 SHALL have ports a_req_i/b_req_i  input  1  lane A (older) / lane B (younger) memory request.
REQ-007 SHALL have ports a_we_i/b_we_i  input  4  byte write enables; 0 = load.
REQ-008 SHALL have ports a_addr_i/b_addr_i and a_wdata_i/b_wdata_i  input  XLEN  address, store data.
REQ-009 SHALL have ports a_gnt_o/b_gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have ports a_rvalid_o/b_rvalid_o  output  1  load data valid; a_rdata_o/b_rdata_o  output  XLEN  load data.
REQ-011 SHALL have ports mem_addr_o, mem_wdata_o  output  XLEN; mem_we_o  output  4; mem_re_o  output  1  data-memory port.
REQ-012 SHALL have port mem_rdata_i  input  XLEN  memory read data, valid the cycle after mem_re_o.
REQ-013 SHALL have port stall_o  output  1  lane B blocked; upstream holds B.
REQ-014 SHALL have port conflict_cnt_o  output  CntWidth  count of same-cycle A+B conflicts.

Function
REQ-015 SHALL implement FSM {IDLE, B_PEND}; at most one access reaches memory per cycle.
REQ-016 Requester SHALL hold req/we/addr/wdata stable until its gnt is sampled high.
REQ-017 IDLE, A only: a_gnt_o=1 combinationally same cycle; state stays IDLE.
REQ-018 IDLE, B only: b_gnt_o=1 same cycle; state stays IDLE.
REQ-019 IDLE, A and B: a_gnt_o=1, b_gnt_o=0, stall_o=1, next state B_PEND, conflict counter +1.
REQ-020 B_PEND: b_gnt_o=1 regardless of a_req_i (program order: pending B older than new A); a_gnt_o=0; stall_o=1 if a_req_i; next state IDLE.
REQ-021 B_PEND with b_req_i low (protocol violation) SHALL return to IDLE with no grant.
REQ-022 Memory port SHALL mux the granted lane: mem_addr_o/mem_wdata_o from it, mem_we_o=its we, mem_re_o=1 iff its we==0; all enables 0 when no grant.
REQ-023 Ungranted cycles SHALL drive mem_addr_o/mem_wdata_o to 0.
REQ-024 Granted load SHALL register owner tag; next cycle owner's rvalid=1 and rdata=mem_rdata_i; other lane rvalid=0, rdata=0.
REQ-025 Load latency SHALL be exactly 1 cycle grant-to-rvalid; back-to-back loads each get rvalid one cycle after their grant.
REQ-026 Stores SHALL produce no rvalid.
REQ-027 flush_i=1: both gnts 0, all memory enables 0, stall_o=0, state -> IDLE, owner tag cleared, rvalid for any load granted the previous cycle suppressed (both rvalid 0).
REQ-028 Stores granted before the flush cycle SHALL stand (already written).
REQ-029 Conflict counter SHALL saturate at 2^CntWidth-1; not incremented on flush cycles.

Reset
REQ-030 On rstn_i low, immediately: state IDLE, owner tag cleared, conflict_cnt_o=0.
REQ-031 During reset all outputs SHALL be 0 (gnts, rvalids, rdata, mem_*, stall_o).
REQ-032 Reset mid-B_PEND SHALL discard the pending B; first cycle after release behaves as IDLE.

Verification
REQ-033 A load addr 0x100, idle -> a_gnt_o=1, mem_re_o=1, mem_addr_o=0x100; next cycle a_rvalid_o=1, a_rdata_o=mem_rdata_i.
REQ-034 A store 0x200 we=0xF + B load 0x204 same cycle -> cycle0 a_gnt_o=1, mem_we_o=0xF, stall_o=1; cycle1 b_gnt_o=1, mem_re_o=1, addr 0x204; cycle2 b_rvalid_o=1; conflict_cnt_o=1.
REQ-035 Conflict then new A request in B_PEND cycle -> B granted first, A granted following cycle, stall_o high both cycles.
REQ-036 A load granted, flush_i next cycle -> a_rvalid_o=0; while in B_PEND, flush_i -> no b_gnt_o, state IDLE.
REQ-037 Force 2^CntWidth+3 conflicts -> conflict_cnt_o saturates at all-ones.
REQ-038 Assert rstn_i low in B_PEND -> outputs 0 asynchronously; after release B-only request granted immediately.
